// File: rtl/isp_pkg.sv
// isp_pkg: shared types and constants for the ISP parameter fetch.
package isp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_VTX,
    S_EMIT,
    S_NEXT
  } fetch_state_e;

  typedef enum logic [1:0] {
    T_STRIP,
    T_TRI_ARRAY,
    T_QUAD_ARRAY,
    T_INVALID
  } opb_type_e;

  // opb_word[31:29] codes for the array types; any code with bit 31 low is a strip
  localparam logic [2:0] OPB_CODE_TRI  = 3'b100;
  localparam logic [2:0] OPB_CODE_QUAD = 3'b101;

  localparam int ISP_TEXTURE_BIT = 25;
  localparam int ISP_UV16_BIT    = 22;

  localparam logic [2:0] HDR_LEN_1V = 3'd3;
  localparam logic [2:0] HDR_LEN_2V = 3'd5;

  function automatic opb_type_e decode_opb_type(input logic [2:0] code);
    if (!code[2])                    return T_STRIP;
    else if (code == OPB_CODE_TRI)   return T_TRI_ARRAY;
    else if (code == OPB_CODE_QUAD)  return T_QUAD_ARRAY;
    else                             return T_INVALID;
  endfunction

  // Index of the highest triangle whose mask bit is set (bit i = triangle i)
  function automatic logic [2:0] strip_last_tri(input logic [5:0] mask);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (mask[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/isp_vert_stride.sv
// isp_vert_stride: vertex stride (in words) and base-colour word offset.
// The caller passes the effective shadow flag, so a single-volume build
// simply ties i_shadow low.
module isp_vert_stride
  import isp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_skip,
  input  logic              i_shadow,
  input  logic [DATA_W-1:0] i_isp_inst,
  output logic [4:0]        o_stride_w,
  output logic [2:0]        o_col_off
);

  logic w_texture;
  logic w_uv16;
  logic w_unused_isp;

  assign w_texture    = i_isp_inst[ISP_TEXTURE_BIT];
  assign w_uv16       = i_isp_inst[ISP_UV16_BIT];
  assign w_unused_isp = ^i_isp_inst;

  // Two-volume vertices carry a second skip block; colour stays at volume 0
  always_comb begin
    o_stride_w = i_shadow ? ({1'b0, i_skip, 1'b0} + 5'd3) : ({2'b00, i_skip} + 5'd3);
    o_col_off  = 3'd3;
    if (w_texture) o_col_off = w_uv16 ? 3'd4 : 3'd5;
  end

endmodule

// File: rtl/isp_param_fetch.sv
// isp_param_fetch: fetches one OPB entry's polygon header and vertices from
// VRAM and emits strip / triangle-array / quad-array primitives.
// Optional macro ISP_TWO_VOLUME_EN: shadow entries use a 5-word header and
// a doubled-skip stride; without it tsp2/tex2 outputs are tied to 0.
//
// state  | meaning
// IDLE   | waiting for render_poly
// HDR    | reading header words
// VTX    | reading x, y, z, colour of the next vertex into the window
// EMIT   | primitive presented, outputs frozen until entry_ready
// NEXT   | advance to the next primitive or finish the entry
module isp_param_fetch
  import isp_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int MAX_STRIP = 6
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [31:0]         i_opb_word,
  input  logic [ADDR_W-1:0]   i_poly_addr,
  input  logic                i_render_poly,
  output logic                o_busy,
  output logic                o_vram_rd,
  output logic [ADDR_W-1:0]   o_vram_addr,
  input  logic [DATA_W-1:0]   i_vram_din,
  input  logic                i_vram_valid,
  output logic [DATA_W-1:0]   o_isp_inst,
  output logic [DATA_W-1:0]   o_tsp_inst,
  output logic [DATA_W-1:0]   o_tex_cont,
  output logic [DATA_W-1:0]   o_tsp2_inst,
  output logic [DATA_W-1:0]   o_tex2_cont,
  output logic [4*DATA_W-1:0] o_vert_x,
  output logic [4*DATA_W-1:0] o_vert_y,
  output logic [4*DATA_W-1:0] o_vert_z,
  output logic [4*DATA_W-1:0] o_vert_col,
  output logic                o_prim_quad,
  output logic                o_entry_valid,
  input  logic                i_entry_ready,
  output logic                o_poly_done
);

  localparam int CNT_W = ($clog2(MAX_STRIP) > 4) ? $clog2(MAX_STRIP) : 4;

  fetch_state_e      r_state;
  opb_type_e         r_type;
  logic [2:0]        r_skip;
  logic              r_shadow;
  logic [5:0]        r_mask;
  logic [CNT_W-1:0]  r_last;
  logic [CNT_W-1:0]  r_prim;
  logic [2:0]        r_fill;
  logic [2:0]        r_wcnt;
  logic [2:0]        r_hdr_last;
  logic [ADDR_W-1:0] r_vbase;
  logic              r_busy, r_rd, r_valid, r_quad, r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_isp_inst, r_tsp_inst, r_tex_cont;
  logic [DATA_W-1:0] r_vx [4];
  logic [DATA_W-1:0] r_vy [4];
  logic [DATA_W-1:0] r_vz [4];
  logic [DATA_W-1:0] r_vc [4];

  opb_type_e         w_in_type;
  logic              w_in_shadow;
  logic [2:0]        w_in_hdr_len;
  logic [5:0]        w_in_mask;
  logic [CNT_W-1:0]  w_in_last;
  logic [4:0]        w_stride_w;
  logic [2:0]        w_col_off;
  logic [ADDR_W-1:0] w_next_vbase;
  logic [ADDR_W-1:0] w_word_addr;
  logic [2:0]        w_need;
  logic              w_emit;
  logic [1:0]        w_slot;
  logic              w_unused_opb;

  assign w_in_type = decode_opb_type(i_opb_word[31:29]);
`ifdef ISP_TWO_VOLUME_EN
  assign w_in_shadow = i_opb_word[24];
`else
  assign w_in_shadow = 1'b0;
`endif
  assign w_in_hdr_len = w_in_shadow ? HDR_LEN_2V : HDR_LEN_1V;
  // Mask bit i belongs to triangle i, which lives at opb_word[30-i]
  assign w_in_mask    = {i_opb_word[25], i_opb_word[26], i_opb_word[27],
                         i_opb_word[28], i_opb_word[29], i_opb_word[30]};
  assign w_in_last    = (w_in_type == T_STRIP) ? CNT_W'(strip_last_tri(w_in_mask))
                                               : CNT_W'(i_opb_word[28:25]);
  assign w_unused_opb = ^{i_opb_word[24], i_opb_word[20:0]};

  isp_vert_stride #(.DATA_W(DATA_W)) u_stride (
    .i_skip     (r_skip),
    .i_shadow   (r_shadow),
    .i_isp_inst (r_isp_inst),
    .o_stride_w (w_stride_w),
    .o_col_off  (w_col_off)
  );

  assign w_next_vbase = r_vbase + ADDR_W'({w_stride_w, 2'b00});
  assign w_need       = (r_type == T_QUAD_ARRAY) ? 3'd4 : 3'd3;
  assign w_emit       = (r_type != T_STRIP) || r_mask[r_prim[2:0]];
  assign w_slot       = r_fill[1:0];

  // Address of the word after the current one within a vertex (UV is jumped over)
  always_comb begin
    w_word_addr = r_vbase + ADDR_W'({w_col_off, 2'b00});
    case (r_wcnt)
      3'd0:    w_word_addr = r_vbase + ADDR_W'(4);
      3'd1:    w_word_addr = r_vbase + ADDR_W'(8);
      default: ;
    endcase
  end

`ifdef ISP_TWO_VOLUME_EN
  logic [DATA_W-1:0] r_tsp2_inst, r_tex2_cont;
  assign o_tsp2_inst = r_tsp2_inst;
  assign o_tex2_cont = r_tex2_cont;
`else
  assign o_tsp2_inst = '0;
  assign o_tex2_cont = '0;
`endif

  // Fetch sequencer: header, vertex window, primitive handshake
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;   r_type <= T_STRIP;  r_skip <= '0;   r_shadow <= 1'b0;
      r_mask <= '0;        r_last <= '0;       r_prim <= '0;   r_fill <= '0;
      r_wcnt <= '0;        r_hdr_last <= '0;   r_vbase <= '0;  r_addr <= '0;
      r_busy <= 1'b0;      r_rd <= 1'b0;       r_valid <= 1'b0;
      r_quad <= 1'b0;      r_done <= 1'b0;
      r_isp_inst <= '0;    r_tsp_inst <= '0;   r_tex_cont <= '0;
`ifdef ISP_TWO_VOLUME_EN
      r_tsp2_inst <= '0;   r_tex2_cont <= '0;
`endif
      for (int i = 0; i < 4; i++) begin
        r_vx[i] <= '0; r_vy[i] <= '0; r_vz[i] <= '0; r_vc[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_render_poly) begin
            r_type     <= w_in_type;
            r_skip     <= i_opb_word[23:21];
            r_shadow   <= w_in_shadow;
            r_mask     <= w_in_mask;
            r_last     <= w_in_last;
            r_hdr_last <= w_in_hdr_len - 3'd1;
            r_prim     <= '0;
            r_fill     <= '0;
            r_wcnt     <= '0;
            r_quad     <= (w_in_type == T_QUAD_ARRAY);
            r_vbase    <= i_poly_addr + ADDR_W'({w_in_hdr_len, 2'b00});
            if (w_in_type == T_INVALID) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_HDR;
              r_busy  <= 1'b1;
              r_rd    <= 1'b1;
              r_addr  <= i_poly_addr;
            end
          end
        end
        S_HDR: begin
          if (r_rd && i_vram_valid) begin
            case (r_wcnt)
              3'd0: r_isp_inst <= i_vram_din;
              3'd1: r_tsp_inst <= i_vram_din;
              3'd2: r_tex_cont <= i_vram_din;
`ifdef ISP_TWO_VOLUME_EN
              3'd3: r_tsp2_inst <= i_vram_din;
              3'd4: r_tex2_cont <= i_vram_din;
`endif
              default: ;
            endcase
            if (r_wcnt == r_hdr_last) begin
              r_wcnt <= '0;
              if (r_type == T_STRIP && r_mask == '0) begin
                r_rd    <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_addr  <= r_vbase;
                r_state <= S_VTX;
              end
            end else begin
              r_wcnt <= r_wcnt + 3'd1;
              r_addr <= r_addr + ADDR_W'(4);
            end
          end
        end
        S_VTX: begin
          if (r_rd && i_vram_valid) begin
            case (r_wcnt)
              3'd0:    r_vx[w_slot] <= i_vram_din;
              3'd1:    r_vy[w_slot] <= i_vram_din;
              3'd2:    r_vz[w_slot] <= i_vram_din;
              default: r_vc[w_slot] <= i_vram_din;
            endcase
            if (r_wcnt != 3'd3) begin
              r_wcnt <= r_wcnt + 3'd1;
              r_addr <= w_word_addr;
            end else begin
              r_wcnt  <= '0;
              r_fill  <= r_fill + 3'd1;
              r_vbase <= w_next_vbase;
              if (r_fill + 3'd1 == w_need) begin
                r_rd <= 1'b0;
                if (w_emit) begin
                  r_valid <= 1'b1;
                  r_state <= S_EMIT;
                end else begin
                  r_state <= S_NEXT;
                end
              end else begin
                r_addr <= w_next_vbase;
              end
            end
          end
        end
        S_EMIT: begin
          if (i_entry_ready) begin
            r_valid <= 1'b0;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_prim == r_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_prim  <= r_prim + CNT_W'(1);
            r_rd    <= 1'b1;
            r_addr  <= r_vbase;
            r_state <= S_VTX;
            if (r_type == T_STRIP) begin
              // Slide the window; only the newest vertex is fetched next
              for (int j = 0; j < 2; j++) begin
                r_vx[j] <= r_vx[j+1]; r_vy[j] <= r_vy[j+1];
                r_vz[j] <= r_vz[j+1]; r_vc[j] <= r_vc[j+1];
              end
              r_fill <= 3'd2;
            end else begin
              r_fill <= 3'd0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_vram_rd     = r_rd;
  assign o_vram_addr   = r_addr;
  assign o_isp_inst    = r_isp_inst;
  assign o_tsp_inst    = r_tsp_inst;
  assign o_tex_cont    = r_tex_cont;
  assign o_vert_x      = {r_vx[3], r_vx[2], r_vx[1], r_vx[0]};
  assign o_vert_y      = {r_vy[3], r_vy[2], r_vy[1], r_vy[0]};
  assign o_vert_z      = {r_vz[3], r_vz[2], r_vz[1], r_vz[0]};
  assign o_vert_col    = {r_vc[3], r_vc[2], r_vc[1], r_vc[0]};
  assign o_prim_quad   = r_quad;
  assign o_entry_valid = r_valid;
  assign o_poly_done   = r_done;

endmodule

// File: tb/tb_isp_param_fetch.sv
// tb_isp_param_fetch: directed vector table plus stall and reset sequences.
`timescale 1ns/1ps
module tb_isp_param_fetch;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  opb_word = '0;
  logic [23:0]  poly_addr = '0;
  logic         render_poly = 1'b0;
  logic         busy, vram_rd;
  logic [23:0]  vram_addr;
  logic [31:0]  vram_din = '0;
  logic         vram_valid = 1'b0;
  logic [31:0]  isp_inst, tsp_inst, tex_cont, tsp2_inst, tex2_cont;
  logic [127:0] vert_x, vert_y, vert_z, vert_col;
  logic         prim_quad, entry_valid, poly_done;
  logic         entry_ready = 1'b1;

  isp_param_fetch dut (
    .i_clock(clk), .i_reset(rst), .i_opb_word(opb_word), .i_poly_addr(poly_addr),
    .i_render_poly(render_poly), .o_busy(busy), .o_vram_rd(vram_rd),
    .o_vram_addr(vram_addr), .i_vram_din(vram_din), .i_vram_valid(vram_valid),
    .o_isp_inst(isp_inst), .o_tsp_inst(tsp_inst), .o_tex_cont(tex_cont),
    .o_tsp2_inst(tsp2_inst), .o_tex2_cont(tex2_cont),
    .o_vert_x(vert_x), .o_vert_y(vert_y), .o_vert_z(vert_z), .o_vert_col(vert_col),
    .o_prim_quad(prim_quad), .o_entry_valid(entry_valid),
    .i_entry_ready(entry_ready), .o_poly_done(poly_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] opb;
    logic [23:0] poly;
    logic [31:0] isp;
    int lat; int hdr; int stride; int col; int reads; int entries;
  } vec_t;

  typedef struct {
    logic [127:0] x, y, z, c;
    logic quad;
  } ent_t;

  vec_t        vecs [9];
  vec_t        cur;
  int          cur_lat = 0;
  ent_t        ents [$];
  logic [23:0] rd_log [$];
  int          done_cnt = 0;
  int          done_start = 0;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          rwait = 0;
  logic [23:0] held_addr = '0;
  logic        force_valid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [23:0] a);
    if (a == cur.poly) return cur.isp;
    return {8'h5A, a};
  endfunction

  function automatic logic [23:0] vb(input int n);
    return cur.poly + 24'(4 * cur.hdr) + 24'(n * cur.stride * 4);
  endfunction

  // VRAM model: answers after cur_lat wait cycles, checks address holds while waiting
  always @(negedge clk) begin
    if (force_valid) begin
      vram_valid = 1'b1;
      vram_din   = 32'hDEAD_BEEF;
    end else if (vram_rd) begin
      if (rwait == 0) held_addr = vram_addr;
      else check("addr_stable", vram_addr, held_addr);
      if (rwait >= cur_lat) begin
        vram_valid = 1'b1;
        vram_din   = mem(vram_addr);
        rd_log.push_back(vram_addr);
        rwait = 0;
      end else begin
        vram_valid = 1'b0;
        rwait++;
      end
    end else begin
      vram_valid = 1'b0;
      rwait = 0;
    end
  end

  // Downstream model: record accepted primitives and poly_done pulses
  always @(negedge clk) begin
    if (entry_valid && entry_ready)
      ents.push_back('{x: vert_x, y: vert_y, z: vert_z, c: vert_col, quad: prim_quad});
    if (poly_done) done_cnt++;
  end

  task automatic start_vec(input int v);
    cur = vecs[v];
    cur_lat = cur.lat;
    rd_log.delete();
    ents.delete();
    done_start = done_cnt;
    @(posedge clk); #1;
    opb_word = cur.opb; poly_addr = cur.poly; render_poly = 1'b1;
    @(posedge clk); #1;
    render_poly = 1'b0;
    check("busy_on_accept", busy, cur.reads > 0);
  endtask

  task automatic compare_results();
    logic [23:0] exp_a [$];
    int firsts [$];
    int nv, need, hits;
    bit quad, strip;
    logic [127:0] ex, ey, ez, ec, m;
    quad  = (cur.opb[31:29] == 3'b101);
    strip = !cur.opb[31];
    need  = quad ? 4 : 3;
    check("read_count", rd_log.size(), cur.reads);
    nv = 0;
    if (cur.reads > 0) begin
      for (int k = 0; k < cur.hdr; k++) exp_a.push_back(cur.poly + 24'(4 * k));
      nv = (cur.reads - cur.hdr) / 4;
    end
    for (int n = 0; n < nv; n++) begin
      exp_a.push_back(vb(n));
      exp_a.push_back(vb(n) + 24'd4);
      exp_a.push_back(vb(n) + 24'd8);
      exp_a.push_back(vb(n) + 24'(4 * cur.col));
    end
    for (int i = 0; i < rd_log.size() && i < exp_a.size(); i++)
      check("read_addr", rd_log[i], exp_a[i]);
    if (cur.col > 3) begin
      hits = 0;
      for (int i = 0; i < rd_log.size(); i++)
        for (int n = 0; n < nv; n++)
          for (int w = 3; w < cur.col; w++)
            if (rd_log[i] == vb(n) + 24'(4 * w)) hits++;
      check("uv_skipped", hits, 0);
    end
    if (cur.reads > 0) begin
      check("isp_inst", isp_inst, cur.isp);
      check("tsp_inst", tsp_inst, mem(cur.poly + 24'd4));
      check("tex_cont", tex_cont, mem(cur.poly + 24'd8));
`ifdef ISP_TWO_VOLUME_EN
      if (cur.hdr == 5) begin
        check("tsp2_inst", tsp2_inst, mem(cur.poly + 24'd12));
        check("tex2_cont", tex2_cont, mem(cur.poly + 24'd16));
      end
`else
      check("tsp2_tied", {tsp2_inst, tex2_cont}, 64'd0);
`endif
    end
    if (strip) begin
      for (int i = 0; i < 6; i++) if (cur.opb[30-i]) firsts.push_back(i);
    end else begin
      for (int p = 0; p < cur.entries; p++) firsts.push_back(p * need);
    end
    check("entry_count", ents.size(), cur.entries);
    for (int k = 0; k < ents.size() && k < firsts.size(); k++) begin
      ex = '0; ey = '0; ez = '0; ec = '0;
      for (int j = 0; j < need; j++) begin
        logic [23:0] b;
        b = vb(firsts[k] + j);
        ex[j*32 +: 32] = mem(b);
        ey[j*32 +: 32] = mem(b + 24'd4);
        ez[j*32 +: 32] = mem(b + 24'd8);
        ec[j*32 +: 32] = mem(b + 24'(4 * cur.col));
      end
      m = quad ? {128{1'b1}} : {32'h0, {96{1'b1}}};
      check("vert_x", ents[k].x & m, ex);
      check("vert_y", ents[k].y & m, ey);
      check("vert_z", ents[k].z & m, ez);
      check("vert_col", ents[k].c & m, ec);
      check("prim_quad", ents[k].quad, quad);
    end
  endtask

  task automatic finish_vec();
    int cyc;
    cyc = 0;
    while (done_cnt == done_start && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", done_cnt != done_start, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - done_start, 1);
    check("busy_after", busy, 1'b0);
    compare_results();
  endtask

  task automatic run_vec(input int v);
    start_vec(v);
    finish_vec();
  endtask

  initial begin
    logic [127:0] snap_x, snap_c;
    int cyc, dsnap;

    //        opb            poly         isp            lat hdr str col reads ent
    vecs[0] = '{32'h8020_0000, 24'h001000, 32'h0000_0000, 0, 3, 4, 3, 15, 1};
    vecs[1] = '{32'hA200_0000, 24'h002000, 32'h0000_0000, 2, 3, 3, 3, 35, 2};
    vecs[2] = '{32'h5000_0000, 24'h003000, 32'h0000_0000, 0, 3, 3, 3, 23, 2};
    vecs[3] = '{32'h8040_0000, 24'h004000, 32'h0240_0000, 1, 3, 5, 4, 15, 1};
    vecs[4] = '{32'h7E00_0000, 24'hFFFFE0, 32'h0000_0000, 1, 3, 3, 3, 35, 6};
    vecs[5] = '{32'h0000_0000, 24'h005000, 32'h0000_0000, 0, 3, 3, 3,  3, 0};
    vecs[6] = '{32'hC000_0000, 24'h006000, 32'h0000_0000, 0, 3, 3, 3,  0, 0};
    vecs[7] = '{32'h8260_0000, 24'h007000, 32'h0200_0000, 0, 3, 6, 5, 27, 2};
`ifdef ISP_TWO_VOLUME_EN
    vecs[8] = '{32'h8140_0000, 24'h008000, 32'h0000_0000, 0, 5, 7, 3, 17, 1};
`else
    vecs[8] = '{32'h8140_0000, 24'h008000, 32'h0000_0000, 0, 3, 5, 3, 15, 1};
`endif
    cur = vecs[0];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {busy, vram_rd, vram_addr, entry_valid, poly_done, prim_quad}, '0);
    check("rst_verts", vert_x | vert_col, '0);
    rst = 1'b0;

    // Stray vram_valid while idle must be ignored
    force_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_valid = 1'b0;
    check("stray_valid_idle", {busy, vram_rd, entry_valid}, '0);
    check("stray_valid_data", isp_inst, 32'h0);

    for (int v = 0; v < 9; v++) run_vec(v);

    // Downstream stall in EMIT, with a render_poly pulse while busy
    entry_ready = 1'b0;
    start_vec(0);
    cyc = 0;
    while (!entry_valid && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall_valid_seen", entry_valid, 1'b1);
    snap_x = vert_x;
    snap_c = vert_col;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin opb_word = 32'hC000_0000; render_poly = 1'b1; end
      if (i == 4) render_poly = 1'b0;
      check("stall_valid", entry_valid, 1'b1);
      check("stall_vert_x", vert_x, snap_x);
      check("stall_vert_col", vert_col, snap_c);
      check("stall_no_rd", vram_rd, 1'b0);
    end
    entry_ready = 1'b1;
    finish_vec();

    // Reset asserted mid-VTX, then a clean restart
    start_vec(1);
    cyc = 0;
    while (rd_log.size() < 6 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_reads_seen", rd_log.size() >= 6, 1'b1);
    dsnap = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {busy, vram_rd, vram_addr, entry_valid, poly_done}, '0);
    check("mid_rst_data", {isp_inst, tsp_inst, tex_cont}, '0);
    check("mid_rst_verts", vert_x | vert_y | vert_z | vert_col, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - dsnap, 0);
    run_vec(0);
    run_vec(2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/isp_param_fetch.md
Name: isp_param_fetch

Overview:
- Parametrised successor to the current ISP object-list parser.
- For one object-pointer-block (OPB) entry, fetches the polygon header and vertices from VRAM over a wait-state-tolerant read handshake.
- Decodes triangle strips (honouring the strip mask), triangle arrays and quad arrays.
- Emits one primitive per valid/ready handshake to the downstream ISP rasteriser setup.

Parameters:
- ADDR_W, 24, VRAM word-address width (byte address, 4-byte aligned).
- DATA_W, 32, VRAM data width; every captured field is DATA_W wide.
- MAX_STRIP, 6, maximum triangles per strip; sizes the strip counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- opb_word  in  32  OPB entry; sampled on accept
- poly_addr  in  ADDR_W  byte address of the polygon header
- render_poly  in  1  start pulse; accepted only in IDLE
- busy  out  1  high from accept until poly_done
- vram_rd  out  1  read request
- vram_addr  out  ADDR_W  read address
- vram_din  in  DATA_W  read data
- vram_valid  in  1  read data valid; completes the current request
- isp_inst, tsp_inst, tex_cont  out  DATA_W each  header words
- tsp2_inst, tex2_cont  out  DATA_W each  second-volume header (see feature)
- vert_x, vert_y, vert_z, vert_col  out  4*DATA_W each  packed vertices A..D, A in the LSBs
- prim_quad  out  1  entry is a quad (vertex D valid)
- entry_valid  out  1  primitive available
- entry_ready  in  1  downstream accepts
- poly_done  out  1  one-cycle pulse when the OPB entry is exhausted

Behaviour:
- Reset: all outputs 0; state IDLE. Reset mid-operation aborts immediately; no poly_done.
- Read handshake:
  - vram_rd and vram_addr are held stable until the cycle vram_valid is high; data is captured that cycle.
  - vram_rd deasserts the next cycle unless another read follows. One read outstanding at a time.
  - vram_valid while vram_rd is low is ignored.
- Type decode:
  - opb_word[31]=0: strip.
  - opb_word[31:29]=100: triangle array.
  - opb_word[31:29]=101: quad array.
  - Other codes: poly_done pulse one cycle after accept; no reads.
- Stride: vertex stride = (skip+3) words, skip=opb_word[23:21]; doubled-skip rule under the feature.
- Vertex fetch:
  - Only x, y, z and base colour are read.
  - Base colour word offset = 3 + (texture ? (uv_16_bit ? 1 : 2) : 0), with texture=isp_inst[25] and uv_16_bit=isp_inst[22].
  - UV words are skipped by address jump, not read.
- States:
  - IDLE -> HDR: on render_poly.
  - HDR: read 3 header words (5 when two-volume) -> VTX.
  - VTX: read 4 words per vertex into the next slot -> EMIT once the window is full.
  - EMIT: entry_valid high; outputs frozen until entry_ready -> NEXT.
  - NEXT: advance primitive -> VTX, or -> IDLE with poly_done.
- Strip:
  - Triangle i uses vertices i, i+1, i+2; its mask bit is opb_word[30-i].
  - Sliding window: slot A<=B, B<=C, and only the new vertex is fetched. Vertices are never re-read.
  - Triangles with mask bit 0 are fetched through but not emitted; odd triangles are not reordered.
  - Strip ends after the highest set mask bit. Mask 0 gives poly_done after the header only.
- Arrays:
  - Triangle array: num_prims+1 triangles (num_prims=opb_word[28:25]), 3 fresh vertices each, consecutive in memory.
  - Quad array: same count, 4 vertices each, prim_quad=1.
- Widths: address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Simultaneous events: render_poly while busy is ignored. entry_ready without entry_valid has no effect.

Optional Feature:
- Macro ISP_TWO_VOLUME_EN.
- Defined: when shadow (opb_word[24]) is set:
  - Header is 5 words; words 3 and 4 go to tsp2_inst and tex2_cont.
  - Stride = 2*skip+3.
  - Base colour offset is unchanged (volume 0).
- Undefined: shadow is ignored for header length and stride; tsp2_inst and tex2_cont are tied to 0.

Decomposition:
- Package isp_pkg: state enum, OPB type codes, ISP instruction bit indices, header length constants.
- One sub-module, isp_vert_stride: combinational stride and base-colour-offset calculator from skip, shadow and isp_inst. Reusable by the TSP parameter fetch.

Test Plan:
- Triangle array, opb=0x8020_0000 (num_prims 0, skip 1), vram_valid every cycle, isp_inst texture=0:
  - 3 header + 12 vertex reads; vertex addresses step 16 bytes.
  - One entry, prim_quad=0; poly_done after entry_ready.
- Quad array, num_prims=1, vram_valid every 3rd cycle:
  - 2 entries with prim_quad=1; vram_addr stable across wait states.
  - Total reads 3+32.
- Strip, mask bits opb[30:25]=101000:
  - Entries for triangles 0 and 2 only; 5 vertex fetches.
  - Triangle 2 entry carries vertices 2,3,4.
- entry_ready held low 10 cycles during EMIT: entry_valid and all vertex outputs stay constant; no new vram_rd.
- Textured, uv_16_bit=1, skip=2: base colour read at vertex offset 4 words; UV word never addressed.
- Reset asserted mid-VTX: outputs 0 the same cycle; next render_poly restarts cleanly. With ISP_TWO_VOLUME_EN defined and shadow=1, skip=2: stride is 7 words.
